// File: rtl/juggle_pkg.sv
// Shared constants and types for the siteswap throw scheduler.
package juggle_pkg;

   localparam int WIDTH   = 3;               // bits per height, ball id, index
   localparam int MAX_LEN = 7;               // longest pattern in beats
   localparam int RING    = 8;               // landing ring depth, > max height
   localparam int RW      = $clog2(RING);    // ring pointer width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      FAULT = 2'd3
   } sched_state_t;

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] height;
      logic [WIDTH-1:0] ball_id;
      logic             hand;
   } throw_t;

endpackage

// File: rtl/landing_ring.sv
// Landing schedule: one slot per future beat, each holding {occupied, ball id}.
// Slot rd_addr is the current beat (read, then cleared); wr_addr is where the
// ball thrown this beat will land. The two never alias since heights < RING.
module landing_ring
   import juggle_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_all,
   input  logic [RW-1:0]    rd_addr,
   input  logic             clr_en,
   input  logic [RW-1:0]    wr_addr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_id,
   output logic             rd_occ,
   output logic [WIDTH-1:0] rd_id,
   output logic             wr_occ
);

   logic [RING-1:0]            occ;
   logic [RING-1:0][WIDTH-1:0] ids;

   assign rd_occ = occ[rd_addr];
   assign rd_id  = ids[rd_addr];
   assign wr_occ = occ[wr_addr];

   // Clear the slot being consumed and book the landing slot of a new throw.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ <= '0;
         ids <= '0;
      end else if (clear_all) begin
         occ <= '0;
         ids <= '0;
      end else begin
         if (clr_en) begin
            occ[rd_addr] <= 1'b0;
            ids[rd_addr] <= '0;
         end
         if (wr_en) begin
            occ[wr_addr] <= 1'b1;
            ids[wr_addr] <= wr_id;
         end
      end
   end

endmodule

// File: rtl/throw_scheduler.sv
// Turns a latched siteswap pattern into one registered throw event per beat,
// tracking landings in a ring and flagging collisions and ball starvation.
module throw_scheduler
   import juggle_pkg::*;
(
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          new_beat,
   input  logic                          start_in,
   input  logic                          stop_in,
   input  logic [MAX_LEN-1:0][WIDTH-1:0] pattern_in,
   input  logic [WIDTH-1:0]              pattern_length,
   input  logic                          pattern_valid_in,
   input  logic [WIDTH-1:0]              num_balls_in,
   output logic                          throw_valid_out,
   output logic [WIDTH-1:0]              throw_height_out,
   output logic [WIDTH-1:0]              ball_id_out,
   output logic                          hand_out,
   output logic [WIDTH-1:0]              beat_index_out,
   output logic                          running_out,
   output logic                          fault_out
);

   sched_state_t                 state;
   logic [MAX_LEN-1:0][WIDTH-1:0] shadow;
   logic [WIDTH-1:0]             shadow_len;
   logic [WIDTH-1:0]             shadow_balls;
   logic [WIDTH-1:0]             idx;
   logic [WIDTH-1:0]             launched;
   logic [RW-1:0]                rp;
   logic                         hand;
   throw_t                       thr_q;

   logic [WIDTH-1:0] h;
   logic [RW-1:0]    tgt;
   logic             beat_act;
   logic             rd_occ, wr_occ;
   logic [WIDTH-1:0] rd_id;
   logic             do_throw, new_ball, fault_ev;
   logic [WIDTH-1:0] ball;

   assign h        = shadow[idx];
   assign tgt      = rp + RW'(h);
   assign beat_act = new_beat && !stop_in && (state == ARMED || state == RUN);

   // Decide this beat's throw: catch-and-rethrow, launch a fresh ball, or fault.
   // A collision suppresses the throw so the faulting beat emits no pulse.
   always_comb begin
      do_throw = 1'b0;
      new_ball = 1'b0;
      fault_ev = 1'b0;
      ball     = launched;
      if (rd_occ) begin
         if (h == '0) fault_ev = 1'b1;
         else begin
            do_throw = 1'b1;
            ball     = rd_id;
         end
      end else if (h != '0) begin
         if (launched < shadow_balls) begin
            do_throw = 1'b1;
            new_ball = 1'b1;
         end else begin
            fault_ev = 1'b1;
         end
      end
      if (do_throw && wr_occ) begin
         fault_ev = 1'b1;
         do_throw = 1'b0;
         new_ball = 1'b0;
      end
   end

   landing_ring u_ring (
      .clk       (clk_in),
      .rst_n     (rst_n_in),
      .clear_all (stop_in),
      .rd_addr   (rp),
      .clr_en    (beat_act && !fault_ev),
      .wr_addr   (tgt),
      .wr_en     (beat_act && do_throw),
      .wr_id     (ball),
      .rd_occ    (rd_occ),
      .rd_id     (rd_id),
      .wr_occ    (wr_occ)
   );

   // Scheduler FSM, beat counters and registered throw outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= IDLE;
         shadow         <= '0;
         shadow_len     <= '0;
         shadow_balls   <= '0;
         idx            <= '0;
         launched       <= '0;
         rp             <= '0;
         hand           <= 1'b0;
         thr_q          <= '0;
         beat_index_out <= '0;
         running_out    <= 1'b0;
         fault_out      <= 1'b0;
      end else begin
         thr_q.valid <= 1'b0;
         if (stop_in) begin
            state          <= IDLE;
            idx            <= '0;
            launched       <= '0;
            rp             <= '0;
            hand           <= 1'b0;
            thr_q          <= '0;
            beat_index_out <= '0;
            running_out    <= 1'b0;
            fault_out      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_in && pattern_valid_in && pattern_length != '0) begin
                     shadow       <= pattern_in;
                     shadow_len   <= pattern_length;
                     shadow_balls <= num_balls_in;
                     state        <= ARMED;
                  end
               end
               ARMED, RUN: begin
                  if (new_beat) begin
                     if (fault_ev) begin
                        state       <= FAULT;
                        fault_out   <= 1'b1;
                        running_out <= 1'b0;
                     end else begin
                        state          <= RUN;
                        running_out    <= 1'b1;
                        rp             <= rp + 1'b1;
                        idx            <= (idx == shadow_len - 1'b1) ? '0 : idx + 1'b1;
                        hand           <= ~hand;
                        thr_q.hand     <= hand;
                        beat_index_out <= idx;
                        if (do_throw) begin
                           thr_q.valid   <= 1'b1;
                           thr_q.height  <= h;
                           thr_q.ball_id <= ball;
                        end
                        if (new_ball) launched <= launched + 1'b1;
                     end
                  end
               end
               default: ;  // FAULT: frozen until stop or reset
            endcase
         end
      end
   end

   assign throw_valid_out  = thr_q.valid;
   assign throw_height_out = thr_q.height;
   assign ball_id_out      = thr_q.ball_id;
   assign hand_out         = thr_q.hand;

endmodule

// File: tb/tb_throw_scheduler.sv
// Scoreboard bench: a timeline model of ball landings predicts every throw;
// a negedge monitor matches DUT pulses against the expected queue.
module tb_throw_scheduler;
   import juggle_pkg::*;

   logic                          clk = 0;
   logic                          rst_n = 0;
   logic                          new_beat = 0, start = 0, stop = 0, pvalid = 0;
   logic [MAX_LEN-1:0][WIDTH-1:0] pattern_in = '0;
   logic [WIDTH-1:0]              pattern_length = '0, num_balls = '0;
   logic                          throw_valid_out, hand_out, running_out, fault_out;
   logic [WIDTH-1:0]              throw_height_out, ball_id_out, beat_index_out;

   throw_scheduler dut (
      .clk_in(clk), .rst_n_in(rst_n), .new_beat(new_beat), .start_in(start),
      .stop_in(stop), .pattern_in(pattern_in), .pattern_length(pattern_length),
      .pattern_valid_in(pvalid), .num_balls_in(num_balls),
      .throw_valid_out(throw_valid_out), .throw_height_out(throw_height_out),
      .ball_id_out(ball_id_out), .hand_out(hand_out), .beat_index_out(beat_index_out),
      .running_out(running_out), .fault_out(fault_out)
   );

   always #5 clk = ~clk;

   typedef struct { int h; int b; int hand; int idx; } exp_t;
   exp_t exp_q[$];
   int   pass_cnt = 0, chk_cnt = 0;

   // Reference model: absolute landing beat per ball, -1 when not airborne.
   int m_pat[MAX_LEN];
   int m_len, m_nb, m_t, m_launched;
   int land[8];
   bit m_armed = 0, m_fault = 0;

   task automatic chk(input string name, input int act, input int req);
      chk_cnt++;
      if (act == req) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endtask

   // Monitor: every throw pulse must match the oldest prediction.
   always @(negedge clk) begin
      if (rst_n && throw_valid_out) begin
         chk_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_throw: got h=%0d ball=%0d with nothing expected",
                     throw_height_out, ball_id_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (throw_height_out == e.h && ball_id_out == e.b &&
                hand_out == e.hand[0] && beat_index_out == e.idx)
               pass_cnt++;
            else
               $display("FAIL throw: got h=%0d b=%0d hand=%0d idx=%0d expected h=%0d b=%0d hand=%0d idx=%0d",
                        throw_height_out, ball_id_out, hand_out, beat_index_out,
                        e.h, e.b, e.hand, e.idx);
         end
      end
   end

   task automatic model_beat();
      int  h, b;
      bit  thr, flt;
      if (!m_armed || m_fault) return;
      h = m_pat[m_t % m_len];
      b = -1; thr = 0; flt = 0;
      for (int i = 0; i < 8; i++) if (land[i] == m_t) b = i;
      if (b >= 0) begin
         if (h == 0) flt = 1; else thr = 1;
      end else if (h > 0) begin
         if (m_launched < m_nb) begin b = m_launched; m_launched++; thr = 1; end
         else flt = 1;
      end
      if (thr)
         for (int i = 0; i < 8; i++) if (i != b && land[i] == m_t + h) flt = 1;
      if (flt) m_fault = 1;
      else begin
         if (thr) begin
            land[b] = m_t + h;
            exp_q.push_back('{h: h, b: b, hand: m_t % 2, idx: m_t % m_len});
         end
         m_t++;
      end
   endtask

   task automatic beat();
      model_beat();
      @(posedge clk); #1 new_beat = 1;
      @(posedge clk); #1 new_beat = 0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
   endtask

   // Arm with m_pat/m_len; inputs are scrambled afterwards to prove latching.
   task automatic arm(input int nb, input bit beat_same_cycle);
      for (int i = 0; i < MAX_LEN; i++)
         pattern_in[i] = (i < m_len) ? WIDTH'(m_pat[i]) : WIDTH'($urandom);
      pattern_length = WIDTH'(m_len);
      num_balls      = WIDTH'(nb);
      pvalid         = 1;
      @(posedge clk); #1 start = 1; new_beat = beat_same_cycle;
      @(posedge clk); #1 start = 0; new_beat = 0;
      pattern_in = {$urandom, $urandom};
      pattern_length = WIDTH'($urandom_range(1, 7));
      num_balls = WIDTH'($urandom);
      m_nb = nb; m_t = 0; m_launched = 0; m_armed = 1; m_fault = 0;
      for (int i = 0; i < 8; i++) land[i] = -1;
   endtask

   task automatic arm_str(input string s, input int nb, input bit same);
      m_len = s.len();
      for (int i = 0; i < m_len; i++) m_pat[i] = s[i] - 8'd48;
      arm(nb, same);
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      chk({tag, "_fault"}, fault_out, m_fault);
      chk({tag, "_running"}, running_out, (m_armed && m_t > 0 && !m_fault) ? 1 : 0);
   endtask

   task automatic do_stop(input string tag);
      @(posedge clk); #1 stop = 1;
      @(posedge clk); #1 stop = 0;
      m_armed = 0; m_fault = 0;
      @(negedge clk);
      chk({tag, "_stop_fault"}, fault_out, 0);
      chk({tag, "_stop_running"}, running_out, 0);
      chk({tag, "_stop_pending"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   string kp[12] = '{"3","441","531","51","423","7","6","53","4","55550","744","5551"};
   int    kb[12] = '{3, 3, 3, 3, 3, 7, 6, 4, 4, 4, 5, 4};

   initial begin
      #12;
      chk("reset_outputs", {throw_valid_out, throw_height_out, ball_id_out, hand_out,
                            beat_index_out, running_out, fault_out}, 0);
      @(negedge clk) rst_n = 1;

      // start without valid is ignored
      m_len = 1; m_pat[0] = 3;
      pattern_in = '0; pattern_in[0] = 3; pattern_length = 1; num_balls = 3; pvalid = 0;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      beat(); beat();
      check_status("novalid");

      arm_str("3", 3, 0);     repeat (9) beat(); check_status("p3");    do_stop("p3");
      arm_str("441", 3, 1);   repeat (6) beat(); check_status("p441");  do_stop("p441");
      arm_str("40", 2, 0);    repeat (4) beat(); check_status("p40");   do_stop("p40");
      arm_str("21", 2, 0);    repeat (4) beat(); check_status("p21");
      chk("p21_faulted", fault_out, 1);
      do_stop("p21");

      // stop wins over a simultaneous start while running
      arm_str("441", 3, 0); repeat (3) beat();
      @(posedge clk); #1 stop = 1; start = 1; pvalid = 1;
      @(posedge clk); #1 stop = 0; start = 0;
      m_armed = 0;
      beat();
      check_status("stopstart");
      chk("stopstart_idle_running", running_out, 0);
      arm_str("51", 3, 0); repeat (5) beat(); check_status("p51"); do_stop("p51");

      // asynchronous reset mid-run
      arm_str("3", 3, 0); repeat (4) beat();
      @(posedge clk); #3 rst_n = 0;
      #1 chk("async_reset_outputs", {throw_valid_out, throw_height_out, ball_id_out,
                                     hand_out, beat_index_out, running_out, fault_out}, 0);
      chk("async_reset_pending", exp_q.size(), 0);
      m_armed = 0; m_fault = 0;
      @(negedge clk) rst_n = 1;
      repeat (3) beat();
      check_status("after_reset");

      // random: known-good patterns and arbitrary (often faulting) ones
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            int k;
            k = $urandom_range(0, 11);
            arm_str(kp[k], kb[k], $urandom_range(0, 1) == 1);
         end else begin
            m_len = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < m_len; i++) m_pat[i] = $urandom_range(0, 7);
            arm($urandom_range(0, 7), 0);
         end
         repeat ($urandom_range(4, 16)) beat();
         check_status("rand");
         do_stop("rand");
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
      $fatal(1);
   end

endmodule
